fetch_controller: RTL
=====================

# fetch_controller

Sequences instruction fetch from the combinational-read instruction memory in the single-cycle processor core. It owns the program counter and drives the memory address each cycle. Fetched words, tagged with their PC, are buffered in a 2-entry queue and presented to decode over a valid/ready handshake. It also applies branch/jump redirects and stops fetching at the end of the memory image.

## Interface
- `ADDRESS_WIDTH`, 32: PC and memory address width.
- `DATA_WIDTH`, 32: instruction width.
- `MEM_SIZE`, 256: instruction memory depth in words; the last fetchable PC is `(MEM_SIZE-1)*4`.
- `RESET_PC`, 32'h0000_0000: PC after reset; must be word aligned.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_addr` out ADDRESS_WIDTH: byte address to instruction memory; equals fetch PC.
- `imem_instr` in DATA_WIDTH: combinational read data for `imem_addr`.
- `redirect_valid` in 1: taken branch/jump this cycle.
- `redirect_pc` in ADDRESS_WIDTH: redirect target.
- `out_valid` out 1: `out_instr`/`out_pc` hold a valid entry.
- `out_ready` in 1: decode accepts the entry when `out_valid && out_ready`.
- `out_instr` out DATA_WIDTH: instruction at the queue head.
- `out_pc` out ADDRESS_WIDTH: PC of `out_instr`.
- `done` out 1: state is HALT and the queue is empty.
- `fault` out 1: misaligned redirect; sticky. Exists only under `FETCH_ALIGN_CHECK_EN` (see Configuration).

## Operation
- States: RUN, HALT, and FAULT (FAULT only under the macro). Reset state is RUN with fetch PC = `RESET_PC`.
- Fetch in RUN:
  - A fetch occurs on a clock edge when the queue is not full, or when it is full and a pop occurs on that same edge.
  - On a fetch, the entry {fetch PC, `imem_instr`} is pushed and the fetch PC increases by 4.
- RUN to HALT: when the fetch PC would reach `MEM_SIZE*4` after incrementing. The final word is still fetched.
- HALT: no pushes. `imem_addr` holds the last value.
- Redirect (`redirect_valid`=1), in RUN or HALT:
  - Any handshake in the same cycle completes first.
  - Then the queue is flushed, fetch PC is set to `redirect_pc`, and the state goes to RUN.
  - No push occurs on the redirect edge.
- Redirect with `redirect_pc >= MEM_SIZE*4`: the state goes to HALT instead.
- Queue: 2-entry FIFO. `out_valid = !empty`. Push and pop on the same edge are allowed in every fill state; the count is then unchanged.
- Address arithmetic: PC increment is modulo 2^ADDRESS_WIDTH. The memory index is `PC[log2(MEM_SIZE)+1:2]`.
- Reset asserted mid-operation: the queue is emptied and all state returns to reset values immediately (asynchronously).

## Timing
- Reset values of outputs:
  - `imem_addr` = `RESET_PC`
  - `out_valid` = 0
  - `out_instr` = 0
  - `out_pc` = 0
  - `done` = 0
  - `fault` = 0
- Start-up: the first edge after `rst_n` rises pushes `RESET_PC`, and `out_valid` goes to 1 after that edge. Latency from address to output is 1 cycle.
- Throughput with `out_ready` held at 1: one instruction per cycle, with consecutive PCs.
- Redirect: `out_valid`=0 during the cycle after the redirect edge. The target instruction is valid one cycle later, so the redirect penalty is 1 bubble.
- `out_instr` and `out_pc` are stable while `out_valid && !out_ready`.

## Configuration
- Macro: `FETCH_ALIGN_CHECK_EN`.
- Defined:
  - A redirect with `redirect_pc[1:0] != 0` enters FAULT: queue flushed, `fault`=1, no further fetches or redirects until reset.
  - `done` stays 0 in FAULT.
- Undefined:
  - The `fault` port is absent.
  - `redirect_pc[1:0]` is forced to 2'b00.

## Structure
- Package `fetch_pkg` contains:
  - `fetch_state_t` enum {RUN, HALT, FAULT}
  - `localparam PC_STEP = 4`
  - `fetch_entry_t` struct {pc, instr}
- Sub-module `fetch_fifo`: a 2-entry `fetch_entry_t` queue with push, pop, flush, full, empty and a head output. The top level holds the PC and the state machine.

## Test plan
- Reset release, memory word k = 32'h1000_0000+k, `out_ready`=1 -> from the first edge after reset, one entry per cycle: `out_pc` 0, 4, 8, … with `out_instr` 0x1000_0000, 0x1000_0001, ….
- `out_ready`=0 for 5 cycles after reset -> queue holds PC 0 and PC 4, `imem_addr` stays 8, and outputs are stable. Raising `out_ready` drains 0, 4, 8 with no gap.
- Redirect to 0x40 while the entry at PC 8 is being handshaken -> PC 8 is consumed, one bubble follows, then `out_pc`=0x40 with instruction 0x1000_0010.
- `MEM_SIZE`=4 with `out_ready`=1 -> PCs 0–0xC are delivered, then `done`=1 and `out_valid`=0. A later redirect to 0 restarts delivery at PC 0.
- Redirect to 0x400 (≥ MEM_SIZE*4) -> queue is flushed, HALT is entered, and `done`=1 on the next cycle.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 0x42 -> `fault`=1, `out_valid`=0, and no further fetches. Asserting `rst_n` low clears `fault`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch unit: FSM state encoding, queue entry layout, PC step.
// The fetch_entry_t field widths set the widths the queue can carry.
package fetch_pkg;

  localparam int FETCH_PC_W    = 32;
  localparam int FETCH_INSTR_W = 32;
  localparam int PC_STEP       = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]    pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetched {pc, instr} entries; supports push+pop on the same
// edge in every fill state, and a flush that drops all entries.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_push_entry,
  output logic         o_full,
  output logic         o_empty,
  output fetch_entry_t o_head
);

  fetch_entry_t r_mem [0:1];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  logic w_pop;
  logic w_push;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_head  = r_mem[r_rd_ptr];

  // A push into a full queue is legal only when the head leaves on the same edge.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // NOTE: the storage is reset as well, so the head output reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, pushes fetched words into a 2-entry
// queue, applies redirects, halts at the end of the image. Option: FETCH_ALIGN_CHECK_EN.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                      ADDRESS_WIDTH = FETCH_PC_W,
  parameter int                      DATA_WIDTH    = FETCH_INSTR_W,
  parameter int                      MEM_SIZE      = 256,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_instr,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic                     done
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                     fault
`endif
);

  localparam logic [ADDRESS_WIDTH-1:0] MEM_LIMIT = ADDRESS_WIDTH'(MEM_SIZE * PC_STEP);
  localparam logic [ADDRESS_WIDTH-1:0] PC_INC    = ADDRESS_WIDTH'(PC_STEP);

  fetch_state_t             r_state;
  fetch_state_t             w_state_next;
  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [ADDRESS_WIDTH-1:0] w_pc_next;
  logic [ADDRESS_WIDTH-1:0] w_pc_inc;
  logic [ADDRESS_WIDTH-1:0] w_redirect_pc;
  logic                     w_misaligned;
  logic                     w_redirect_taken;
  logic                     w_fetch;
  logic                     w_pop;
  logic                     w_flush;
  logic                     w_full;
  logic                     w_empty;
  fetch_entry_t             w_push_entry;
  fetch_entry_t             w_head;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misaligned  = (redirect_pc[1:0] != 2'b00);
  assign w_redirect_pc = redirect_pc;
`else
  assign w_misaligned  = 1'b0;
  assign w_redirect_pc = redirect_pc & ~ADDRESS_WIDTH'(3);
`endif

  assign w_pc_inc         = r_pc + PC_INC;
  assign w_pop            = out_valid && out_ready;
  assign w_redirect_taken = redirect_valid && (r_state != FAULT);
  // The fetch uses the queue slot freed by a same-edge pop when the queue is full.
  assign w_fetch          = (r_state == RUN) && !w_redirect_taken && (!w_full || w_pop);

  assign w_push_entry.pc    = r_pc;
  assign w_push_entry.instr = imem_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_flush      = 1'b0;
    if (w_redirect_taken) begin
      w_flush = 1'b1;
      if (w_misaligned) begin
        w_state_next = FAULT;
      end else if (w_redirect_pc >= MEM_LIMIT) begin
        w_state_next = HALT;
      end else begin
        w_state_next = RUN;
        w_pc_next    = w_redirect_pc;
      end
    end else if (w_fetch) begin
      // The last word is fetched, but the PC stays on it once the image is exhausted.
      if (w_pc_inc >= MEM_LIMIT) begin
        w_state_next = HALT;
      end else begin
        w_pc_next = w_pc_inc;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_fetch),
    .i_pop        (w_pop),
    .i_flush      (w_flush),
    .i_push_entry (w_push_entry),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_head       (w_head)
  );

  assign imem_addr = r_pc;
  assign out_valid = !w_empty;
  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;
  assign done      = (r_state == HALT) && w_empty;

`ifdef FETCH_ALIGN_CHECK_EN
  assign fault = (r_state == FAULT);
`endif

endmodule
